// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: owner state encoding, blank/reset constants, counter width
// helper, one-hot grant encoder and the arbiter next-owner decision.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_e;

    // Dot mask is active-low per digit, so "all dots off" is all ones.
    localparam logic [3:0]  POINT_OFF = 4'hF;
    localparam logic [31:0] BLANK_NUM = 32'h0;

    // Counter width for a modulus n: $clog2(n), never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] grant_of(input owner_e st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Next owner at a frame boundary. last=1 means source 1 was the most
    // recent owner, so a simultaneous request from idle goes to source 0.
    function automatic owner_e arb_next(input owner_e cur,
                                        input logic   req0,
                                        input logic   req1,
                                        input logic   last,
                                        input logic   hold_zero);
        owner_e nxt;
        nxt = ST_IDLE;
        case (cur)
            ST_IDLE: begin
                if (req0 && req1)  nxt = last ? ST_OWN0 : ST_OWN1;
                else if (req0)     nxt = ST_OWN0;
                else if (req1)     nxt = ST_OWN1;
                else               nxt = ST_IDLE;
            end
            ST_OWN0: begin
                if (!req0)                  nxt = req1 ? ST_OWN1 : ST_IDLE;
                else if (req1 && hold_zero) nxt = ST_OWN1;
                else                        nxt = ST_OWN0;
            end
            ST_OWN1: begin
                if (!req1)                  nxt = req0 ? ST_OWN0 : ST_IDLE;
                else if (req0 && hold_zero) nxt = ST_OWN0;
                else                        nxt = ST_OWN1;
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Digit-scan divider, frame boundary detect and blink clock generator.
// Latency: Scanning/flash_clk/frame_start are registered; boundary is combinational from state.
// Backpressure: none; free-running from reset.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   Scanning      active digit index 0..3, advances every SCAN_DIV cycles
//   boundary      high in the last cycle of a frame (digit 3, last slot cycle)
//   frame_start   one-cycle pulse in the first cycle of every frame after the first
//   flash_clk     blink phase, toggles every FLASH_DIV frames
module scan_timer
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] Scanning,
    output logic       boundary,
    output logic       frame_start,
    output logic       flash_clk
);

    localparam int DIV_W = cnt_width(SCAN_DIV);
    localparam int FRM_W = cnt_width(FLASH_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FLASH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic             tick;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (Scanning == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            Scanning    <= 2'd0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            flash_clk   <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt  <= '0;
                Scanning <= Scanning + 2'd1;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end

            // Registered copy of boundary lands on the first digit-0 cycle.
            frame_start <= boundary;

            if (boundary) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt <= '0;
                    flash_clk <= ~flash_clk;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan sequencer and two-source arbiter for the 4-digit 7-segment driver.
// Latency: request/data sampled in the boundary cycle appear on the next edge with Scanning=0.
// Backpressure: none; requests are levels, only sampled at frame boundaries, never queued.
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   srcN_req/_num/_point/_blink      requester N: level request, 8-nibble number, dot mask (1=off), blink mask
//   grant                            one-hot owner, 2'b00 when idle
//   frame_start, Scanning, flash_clk scan timing (see scan_timer)
//   disp_num, pointing, blinking     owner's fields, frozen for the whole frame
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int FLASH_DIV   = 64,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src0_req,
    input  logic [31:0] src0_num,
    input  logic [3:0]  src0_point,
    input  logic [3:0]  src0_blink,
    input  logic        src1_req,
    input  logic [31:0] src1_num,
    input  logic [3:0]  src1_point,
    input  logic [3:0]  src1_blink,
    output logic [1:0]  grant,
    output logic        frame_start,
    output logic [1:0]  Scanning,
    output logic        flash_clk,
    output logic [31:0] disp_num,
    output logic [3:0]  pointing,
    output logic [3:0]  blinking
);

    localparam int HOLD_W = cnt_width(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES - 1);

    logic              boundary;
    owner_e            state;
    owner_e            nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last;

    scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .FLASH_DIV (FLASH_DIV)
    ) u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .Scanning    (Scanning),
        .boundary    (boundary),
        .frame_start (frame_start),
        .flash_clk   (flash_clk)
    );

    // Decision only matters when boundary is high; it is ignored otherwise.
    assign nxt = arb_next(state, src0_req, src1_req, last, (hold_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= 2'b00;
            disp_num <= BLANK_NUM;
            pointing <= POINT_OFF;
            blinking <= 4'h0;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else if (boundary) begin
            state <= nxt;
            grant <= grant_of(nxt);

            // Frame data is captured from whoever owns the coming frame, on
            // the same edge that wraps Scanning to 0, so a frame never tears.
            case (nxt)
                ST_OWN0: begin
                    disp_num <= src0_num;
                    pointing <= src0_point;
                    blinking <= src0_blink;
                end
                ST_OWN1: begin
                    disp_num <= src1_num;
                    pointing <= src1_point;
                    blinking <= src1_blink;
                end
                default: begin
                    disp_num <= BLANK_NUM;
                    pointing <= POINT_OFF;
                    blinking <= 4'h0;
                end
            endcase

            if (nxt != ST_IDLE) begin
                if (nxt != state) begin
                    hold_cnt <= HOLD_INIT;
                    last     <= (nxt == ST_OWN1);
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: main instance SCAN_DIV=4 (16-cycle
// frames), second instance SCAN_DIV=1 (4-cycle frames) sharing clk/rst.
// Cycle n = state seen 1 time unit after the n-th edge following reset release.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance stimulus/observation.
    logic        src0_req, src1_req;
    logic [31:0] src0_num, src1_num;
    logic [3:0]  src0_point, src0_blink, src1_point, src1_blink;
    logic [1:0]  grant, Scanning;
    logic        frame_start, flash_clk;
    logic [31:0] disp_num;
    logic [3:0]  pointing, blinking;

    // SCAN_DIV=1 instance.
    logic        b_src0_req, b_src1_req;
    logic [31:0] b_src0_num, b_src1_num;
    logic [3:0]  b_src0_point, b_src0_blink, b_src1_point, b_src1_blink;
    logic [1:0]  b_grant, b_Scanning;
    logic        b_frame_start, b_flash_clk;
    logic [31:0] b_disp_num;
    logic [3:0]  b_pointing, b_blinking;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    display_scan_ctrl #(.SCAN_DIV(4), .FLASH_DIV(2), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .src0_req(src0_req), .src0_num(src0_num), .src0_point(src0_point), .src0_blink(src0_blink),
        .src1_req(src1_req), .src1_num(src1_num), .src1_point(src1_point), .src1_blink(src1_blink),
        .grant(grant), .frame_start(frame_start), .Scanning(Scanning), .flash_clk(flash_clk),
        .disp_num(disp_num), .pointing(pointing), .blinking(blinking)
    );

    display_scan_ctrl #(.SCAN_DIV(1), .FLASH_DIV(2), .HOLD_FRAMES(2)) dut1 (
        .clk(clk), .rst(rst),
        .src0_req(b_src0_req), .src0_num(b_src0_num), .src0_point(b_src0_point), .src0_blink(b_src0_blink),
        .src1_req(b_src1_req), .src1_num(b_src1_num), .src1_point(b_src1_point), .src1_blink(b_src1_blink),
        .grant(b_grant), .frame_start(b_frame_start), .Scanning(b_Scanning), .flash_clk(b_flash_clk),
        .disp_num(b_disp_num), .pointing(b_pointing), .blinking(b_blinking)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to cycle n, sampling 1 unit after each rising edge.
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        src0_req = 1'b0; src0_num = '0; src0_point = 4'h0; src0_blink = 4'h0;
        src1_req = 1'b0; src1_num = '0; src1_point = 4'h0; src1_blink = 4'h0;
        b_src0_req = 1'b0; b_src0_num = '0; b_src0_point = 4'h0; b_src0_blink = 4'h0;
        b_src1_req = 1'b0; b_src1_num = '0; b_src1_point = 4'h0; b_src1_blink = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Reset state.
        chk("rst_scan",   32'(Scanning),    32'd0);
        chk("rst_flash",  32'(flash_clk),   32'd0);
        chk("rst_fs",     32'(frame_start), 32'd0);
        chk("rst_grant",  32'(grant),       32'd0);
        chk("rst_num",    disp_num,         32'h0);
        chk("rst_point",  32'(pointing),    32'hF);
        chk("rst_blink",  32'(blinking),    32'h0);
        chk("b_rst_scan", 32'(b_Scanning),  32'd0);

        // SCAN_DIV=1: one digit per clock, 4-cycle frames.
        go(1);  chk("b_scan1", 32'(b_Scanning), 32'd1);
        go(2);  chk("b_scan2", 32'(b_Scanning), 32'd2);
        go(3);  chk("b_scan3", 32'(b_Scanning), 32'd3);
                chk("b_fs3",   32'(b_frame_start), 32'd0);
        go(4);  chk("scan_c4", 32'(Scanning),   32'd1);
                chk("b_scan4", 32'(b_Scanning), 32'd0);
                chk("b_fs4",   32'(b_frame_start), 32'd1);
        go(5);  chk("b_fs5",   32'(b_frame_start), 32'd0);
                b_src0_req = 1'b1; b_src0_num = 32'h0000BEEF;
        go(7);  chk("b_grant_c7", 32'(b_grant), 32'd0);
        go(8);  chk("b_grant_c8", 32'(b_grant), 32'd1);
                chk("b_num_c8",   b_disp_num,   32'h0000BEEF);
                chk("b_fs8",      32'(b_frame_start), 32'd1);
                chk("scan_c8",    32'(Scanning), 32'd2);
        go(12); chk("scan_c12",   32'(Scanning), 32'd3);
        go(15); chk("fs_c15",     32'(frame_start), 32'd0);
                chk("scan_c15",   32'(Scanning), 32'd3);
        go(16); chk("fs_c16",     32'(frame_start), 32'd1);
                chk("scan_c16",   32'(Scanning), 32'd0);
                chk("grant_c16",  32'(grant), 32'd0);
                chk("point_c16",  32'(pointing), 32'hF);
        go(17); chk("fs_c17",     32'(frame_start), 32'd0);

        // Mid-frame request takes effect only at the next boundary.
        go(20);
        src0_req = 1'b1; src0_num = 32'h12345678; src0_point = 4'h5; src0_blink = 4'h3;
        go(31); chk("grant_c31", 32'(grant), 32'd0);
                chk("num_c31",   disp_num, 32'h0);
                chk("flash_c31", 32'(flash_clk), 32'd0);
        go(32); chk("grant_c32", 32'(grant), 32'd1);
                chk("num_c32",   disp_num, 32'h12345678);
                chk("point_c32", 32'(pointing), 32'h5);
                chk("blink_c32", 32'(blinking), 32'h3);
                chk("flash_c32", 32'(flash_clk), 32'd1);
                chk("fs_c32",    32'(frame_start), 32'd1);
        go(36); src0_num = 32'hAABBCCDD;
        go(47); chk("num_hold_c47", disp_num, 32'h12345678);
        go(48); chk("num_c48",      disp_num, 32'hAABBCCDD);

        // Both requesting: each owner keeps two frames, then alternates.
        go(50);
        src1_req = 1'b1; src1_num = 32'h11112222; src1_point = 4'hA; src1_blink = 4'hC;
        go(63);  chk("grant_c63",  32'(grant), 32'd1);
                 chk("flash_c63",  32'(flash_clk), 32'd1);
        go(64);  chk("grant_c64",  32'(grant), 32'd2);
                 chk("num_c64",    disp_num, 32'h11112222);
                 chk("flash_c64",  32'(flash_clk), 32'd0);
        go(80);  chk("grant_c80",  32'(grant), 32'd2);
        go(96);  chk("grant_c96",  32'(grant), 32'd1);
                 chk("num_c96",    disp_num, 32'hAABBCCDD);
        go(112); chk("grant_c112", 32'(grant), 32'd1);
        go(128); chk("grant_c128", 32'(grant), 32'd2);
                 chk("point_c128", 32'(pointing), 32'hA);
                 chk("blink_c128", 32'(blinking), 32'hC);

        // Owner drops: other source takes over; then nobody -> idle blank.
        go(130); src1_req = 1'b0;
        go(144); chk("grant_c144", 32'(grant), 32'd1);
        go(146); src0_req = 1'b0;
        go(159); chk("flash_c159", 32'(flash_clk), 32'd0);
        go(160); chk("grant_c160", 32'(grant), 32'd0);
                 chk("num_c160",   disp_num, 32'h0);
                 chk("point_c160", 32'(pointing), 32'hF);
                 chk("blink_c160", 32'(blinking), 32'h0);
                 chk("flash_c160", 32'(flash_clk), 32'd1);

        // Request pulse entirely inside a frame is ignored.
        go(162); src1_req = 1'b1;
        go(170); src1_req = 1'b0;
        go(176); chk("grant_pulse_c176", 32'(grant), 32'd0);
                 src0_req = 1'b1; src0_num = 32'hCAFEF00D;
        go(192); chk("grant_c192", 32'(grant), 32'd1);
                 chk("num_c192",   disp_num, 32'hCAFEF00D);
        go(198); chk("grant_c198", 32'(grant), 32'd1);
                 chk("scan_c198",  32'(Scanning), 32'd1);

        // Mid-frame reset, both sources requesting through it.
        rst = 1'b1;
        src1_req = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        chk("mrst_scan",  32'(Scanning),    32'd0);
        chk("mrst_grant", 32'(grant),       32'd0);
        chk("mrst_num",   disp_num,         32'h0);
        chk("mrst_point", 32'(pointing),    32'hF);
        chk("mrst_blink", 32'(blinking),    32'h0);
        chk("mrst_flash", 32'(flash_clk),   32'd0);
        chk("mrst_fs",    32'(frame_start), 32'd0);
        rst = 1'b0;
        go(4);  chk("mrst_scan_c4", 32'(Scanning), 32'd1);
        go(16); chk("both_grant_c16", 32'(grant), 32'd1);
                chk("both_num_c16",   disp_num, 32'hCAFEF00D);
                chk("both_fs_c16",    32'(frame_start), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
